cory_mux_arb: RTL
=================

# cory_mux_arb

Round-robin select generator that sits directly upstream of the select channel of `cory_mux`. It snoops the same R per-input valid lines the mux sees, and issues one select token per data beat on a valid/ready channel that connects to the mux's `i_s_*` port. The arbitration is work-conserving. Back-to-back tokens are issued whenever at least two inputs are requesting.

## Interface
Parameters:
- `R`, 4: number of requesters; legal range 2..32.
- `S`, derived: select width; 1 for R≤2, 2 for R≤4, 3 for R≤8, 4 for R≤16, 5 for R≤32. Do not override.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `i_a_v`  in  R: snooped valid of each mux data input; bit k = input k.
- `o_s_v`  out  1: select token valid; drives mux `i_s_v`.
- `o_s_d`  out  S: select token; index of the granted input; drives mux `i_s_d`.
- `i_s_r`  in  1: token accepted; driven by mux `o_s_r`.

## Operation
- State:
  - output register {`o_s_v`, `o_s_d`};
  - `last` [S-1:0], the index of the most recently issued token.
- Reset values: `o_s_v`=0, `o_s_d`=0, `last`=R-1, so the first search starts at 0.
- `acc` = `o_s_v & i_s_r`, a token handshake in the current cycle.
- `load` = `!o_s_v | i_s_r`, meaning the output register may take a new value.
- Candidate set `C` = `i_a_v & ~(acc ? onehot(o_s_d) : 0)`.
  - In a handshake cycle, the input being consumed still shows valid for that beat, so it is masked out.
  - Its remaining beats are picked up once its valid has settled, one cycle later.
- Pick: the first set bit of `C` scanning `last+1, last+2, …` modulo R, wrapping from R-1 to 0.
- On `load`:
  - If `C`≠0: `o_s_v`<=1, `o_s_d`<=pick, `last`<=pick.
  - If `C`=0: `o_s_v`<=0; `o_s_d` and `last` hold.
- If not `load` (token pending and not accepted): everything holds.
  - `o_s_d` stays stable until accepted, even if `i_a_v[o_s_d]` deasserts.
  - Changes on other `i_a_v` bits are ignored.
- `i_s_r` while `o_s_v`=0 has no effect beyond allowing the load.
- `o_s_v` never depends combinationally on `i_s_r` or `i_a_v`, because it is a registered output.
- A token's index always had `i_a_v` set in the cycle it was loaded.

## Timing
- Latency: `i_a_v` rising with the arbiter idle gives `o_s_v`=1 the next cycle.
- Throughput:
  - With ≥2 inputs continuously valid and `i_s_r`=1, one token is issued per cycle in strict rotation.
  - With a single continuously valid input, tokens for that input are issued every other cycle, with one bubble after each accept.
- Fairness: between two tokens to input k, every other input that was valid at each load point is granted at most once.
- Reset mid-operation: on assertion, outputs go to their reset values immediately (asynchronous). Any pending token is dropped, and arbitration restarts from input 0.
- Value constraint: `o_s_d` < R always. The modulo-R wrap must be correct for non-power-of-two R (R=3, 5, …).

## Structure
- Shared package `cory_pkg`: the width rule that derives S from R, as a constant function `cory_clog2_sel(R)`. Use it here and in `cory_mux` instead of the nested conditional.
- Sub-module `cory_rr_pick` (combinational):
  - inputs: request vector `C` and `last`;
  - outputs: `any` and `idx`;
  - implementation: double-width rotate plus find-first, reusable by other arbiters in the library.
- Top level: the output register, the `last` register, and the mask and load logic.

## Test plan
- Reset: hold `reset_n`=0 with `i_a_v`=4'b1111 → `o_s_v`=0, `o_s_d`=0. Release → the next cycle gives `o_s_v`=1, `o_s_d`=0.
- Full rotation: R=4, `i_a_v`=4'b1111 held, `i_s_r`=1 → `o_s_d` sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Single requester: `i_a_v`=4'b0100 held, `i_s_r`=1 → tokens 2,–,2,–,2 (`o_s_v` toggles 1,0,1,0).
- Backpressure:
  - Token 1 pending, `i_s_r`=0 for 5 cycles, `i_a_v` bit 1 drops and bit 3 rises → `o_s_d`=1 stable throughout.
  - Raising `i_s_r` → next token is 3.
- Wrap with R=3: `last`=2, `i_a_v`=3'b011 → pick 0, then 1, then 0. `o_s_d` is never 3.
- Reset mid-operation: assert `reset_n`=0 asynchronously mid-cycle while token 2 is pending → `o_s_v` falls without a clock edge. After release with all valid, the first token is 0.

Source files
------------

// File: rtl/cory_pkg.sv
// Shared constants and helpers for the cory mux/arbiter library.
// Select width is derived here so the mux and its arbiter always agree.
package cory_pkg;

    // Width of a select index for r requesters (r in 2..32).
    function automatic int cory_clog2_sel(input int r);
        if (r <= 2) begin
            return 1;
        end else if (r <= 4) begin
            return 2;
        end else if (r <= 8) begin
            return 3;
        end else if (r <= 16) begin
            return 4;
        end else begin
            return 5;
        end
    endfunction

endpackage

// File: rtl/cory_rr_pick.sv
// Combinational round-robin pick: first set bit of req scanning from last+1
// upward, wrapping modulo R. Works for non-power-of-two R.
module cory_rr_pick
    import cory_pkg::*;
#(
    parameter int R = 4,
    parameter int S = cory_clog2_sel(R)
) (
    input  logic [R-1:0] req,
    input  logic [S-1:0] last,
    output logic         any,
    output logic [S-1:0] idx
);

    logic [2*R-1:0] dbl_sh;
    logic [R-1:0]   rot;
    int             start;
    int             off;
    int             pos;

    always_comb begin
        start  = int'(last) + 1;
        // Doubling the vector turns the modulo-R rotate into a plain shift.
        dbl_sh = {req, req} >> start;
        rot    = dbl_sh[R-1:0];
        any    = |req;
        off    = 0;
        for (int j = R - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        pos = start + off;
        if (pos >= R) begin
            pos = pos - R;
        end
        idx = S'(pos);
    end

endmodule

// File: rtl/cory_mux_arb.sv
// Round-robin select-token generator feeding the select channel of cory_mux.
// One registered token per data beat; the beat being consumed is masked out.
module cory_mux_arb
    import cory_pkg::*;
#(
    parameter int R = 4,
    parameter int S = cory_clog2_sel(R)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [R-1:0] i_a_v,
    output logic         o_s_v,
    output logic [S-1:0] o_s_d,
    input  logic         i_s_r
);

    // Token channel: a token is transferred in any cycle where o_s_v and
    // i_s_r are both high; o_s_d is held stable while o_s_v waits for i_s_r.

    logic         o_s_v_q, o_s_v_d;
    logic [S-1:0] o_s_d_q, o_s_d_d;
    logic [S-1:0] last_q, last_d;

    logic         acc;
    logic         load;
    logic [R-1:0] mask;
    logic [R-1:0] cand;
    logic         pick_any;
    logic [S-1:0] pick_idx;

    always_comb begin
        acc  = o_s_v_q & i_s_r;
        load = ~o_s_v_q | i_s_r;
        mask = acc ? ({{(R-1){1'b0}}, 1'b1} << o_s_d_q) : '0;
        cand = i_a_v & ~mask;
    end

    cory_rr_pick #(
        .R(R),
        .S(S)
    ) u_pick (
        .req (cand),
        .last(last_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        o_s_v_d = o_s_v_q;
        o_s_d_d = o_s_d_q;
        last_d  = last_q;
        if (load) begin
            if (pick_any) begin
                o_s_v_d = 1'b1;
                o_s_d_d = pick_idx;
                last_d  = pick_idx;
            end else begin
                o_s_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_s_v_q <= 1'b0;
            o_s_d_q <= '0;
            last_q  <= S'(R - 1);
        end else begin
            o_s_v_q <= o_s_v_d;
            o_s_d_q <= o_s_d_d;
            last_q  <= last_d;
        end
    end

    assign o_s_v = o_s_v_q;
    assign o_s_d = o_s_d_q;

endmodule
